// File: rtl/pong_pkg.sv
// pong_pkg: shared types and default parameters for the Pong match logic
package pong_pkg;

    localparam int SCORE_W          = 4;
    localparam int WIN_SCORE_DEF    = 7;
    localparam int SERVE_DELAY_DEF  = 120;
    localparam int FRAME_CLKS_DEF   = 830001;

    typedef enum logic [1:0] {
        IDLE       = 2'd0,
        SERVE_WAIT = 2'd1,
        RALLY      = 2'd2,
        GAME_OVER  = 2'd3
    } match_state_t;

    typedef enum logic [1:0] {
        WIN_NONE = 2'b00,
        WIN_P1   = 2'b01,
        WIN_P2   = 2'b10
    } winner_t;

endpackage

// File: rtl/pong_frame_tick.sv
// pong_frame_tick: free-running frame counter emitting a one-clk tick at count 0
module pong_frame_tick
    import pong_pkg::*;
#(
    parameter int FRAME_CLKS = FRAME_CLKS_DEF
) (
    input  logic clk,
    input  logic reset,
    output logic tick
);

    localparam int CW = (FRAME_CLKS > 1) ? $clog2(FRAME_CLKS) : 1;

    logic [CW-1:0] cnt_q;

    // wrap the counter at FRAME_CLKS-1 so the tick period is exactly FRAME_CLKS
    always_ff @(posedge clk or posedge reset) begin
        if (reset) cnt_q <= '0;
        else       cnt_q <= (cnt_q == CW'(FRAME_CLKS - 1)) ? '0 : cnt_q + 1'b1;
    end

    assign tick = (cnt_q == '0);

endmodule

// File: rtl/pong_match_ctrl.sv
// pong_match_ctrl: match FSM turning point pulses into scores, serves and a winner
module pong_match_ctrl
    import pong_pkg::*;
#(
    parameter int WIN_SCORE   = WIN_SCORE_DEF,
    parameter int SERVE_DELAY = SERVE_DELAY_DEF,
    parameter int FRAME_CLKS  = FRAME_CLKS_DEF
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               start_btn,
    input  logic               point_p1,
    input  logic               point_p2,
    output logic               serve,
    output logic               field_clr,
    output logic [SCORE_W-1:0] score_p1,
    output logic [SCORE_W-1:0] score_p2,
    output logic [1:0]         winner,
    output logic [1:0]         state_o
);

    logic               tick;
    logic               start_q;
    logic               start_edge;
    match_state_t       state_q;
    logic [7:0]         srv_cnt_q;
    logic               serve_q;
    logic               field_clr_q;
    logic [SCORE_W-1:0] score_p1_q;
    logic [SCORE_W-1:0] score_p2_q;
    winner_t            winner_q;
    logic [SCORE_W-1:0] p1_inc;
    logic [SCORE_W-1:0] p2_inc;

    pong_frame_tick #(.FRAME_CLKS(FRAME_CLKS)) u_tick (
        .clk   (clk),
        .reset (reset),
        .tick  (tick)
    );

    assign start_edge = start_btn & ~start_q;
    assign p1_inc     = score_p1_q + 1'b1;
    assign p2_inc     = score_p2_q + 1'b1;

    // match sequencing: start/restart, timed serve pause, point crediting and win detection
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            start_q     <= 1'b0;
            state_q     <= IDLE;
            srv_cnt_q   <= '0;
            serve_q     <= 1'b0;
            field_clr_q <= 1'b0;
            score_p1_q  <= '0;
            score_p2_q  <= '0;
            winner_q    <= WIN_NONE;
        end else begin
            start_q     <= start_btn;
            serve_q     <= 1'b0;
            field_clr_q <= 1'b0;
            case (state_q)
                IDLE, GAME_OVER: begin
                    if (start_edge) begin
                        state_q     <= SERVE_WAIT;
                        srv_cnt_q   <= '0;
                        score_p1_q  <= '0;
                        score_p2_q  <= '0;
                        winner_q    <= WIN_NONE;
                        field_clr_q <= 1'b1;
                    end
                end
                SERVE_WAIT: begin
                    if (tick) begin
                        if (srv_cnt_q == 8'(SERVE_DELAY - 1)) begin
                            serve_q <= 1'b1;
                            state_q <= RALLY;
                        end else begin
                            srv_cnt_q <= srv_cnt_q + 1'b1;
                        end
                    end
                end
                RALLY: begin
                    // player 1 has priority when both pulses land together
                    if (point_p1) begin
                        score_p1_q <= p1_inc;
                        srv_cnt_q  <= '0;
                        if (p1_inc == SCORE_W'(WIN_SCORE)) begin
                            state_q  <= GAME_OVER;
                            winner_q <= WIN_P1;
                        end else begin
                            state_q <= SERVE_WAIT;
                        end
                    end else if (point_p2) begin
                        score_p2_q <= p2_inc;
                        srv_cnt_q  <= '0;
                        if (p2_inc == SCORE_W'(WIN_SCORE)) begin
                            state_q  <= GAME_OVER;
                            winner_q <= WIN_P2;
                        end else begin
                            state_q <= SERVE_WAIT;
                        end
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign serve     = serve_q;
    assign field_clr = field_clr_q;
    assign score_p1  = score_p1_q;
    assign score_p2  = score_p2_q;
    assign winner    = winner_q;
    assign state_o   = state_q;

endmodule
